vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 4, system clocks per pixel; legal range 2..16.
REQ-002 Parameter H_ACT/H_FP/H_SYNC/H_BP, default 640/16/96/48, horizontal pixel counts (total 800).
REQ-003 Parameter V_ACT/V_FP/V_SYNC/V_BP, default 480/10/2/33, vertical line counts (total 525).
REQ-004 Parameter FG_COLOR, default 12'hFFF, RGB444 colour driven for a lit pixel.
REQ-005 Port clk, input, 1, system clock; every flop is on its rising edge.
REQ-006 Port rst, input, 1, asynchronous active-low reset.
REQ-007 Port px_data, input, 1, pixel-lit flag from the video encoder for the current x/y.
REQ-008 Port x, output, 11, current pixel column, 0..799.
REQ-009 Port y, output, 11, current line, 0..524.
REQ-010 Port px_tick, output, 1, one-clk pulse on the last clock of each pixel period.
REQ-011 Port frame_tick, output, 1, one-clk pulse at the end of each frame.
REQ-012 Port video_on, output, 1, high when the current x/y is in the active area.
REQ-013 Port hsync, output, 1, horizontal sync, active-low.
REQ-014 Port vsync, output, 1, vertical sync, active-low.
REQ-015 Port vga_r, output, 4, red channel.
REQ-016 Port vga_g, output, 4, green channel.
REQ-017 Port vga_b, output, 4, blue channel.

Function
REQ-018 Counter div_cnt shall count 0..CLK_DIV-1 and wrap to 0.
REQ-019 px_tick shall be a combinational decode of div_cnt == CLK_DIV-1.
REQ-020 On px_tick, x shall increment; at x == 799 it shall wrap to 0 instead.
REQ-021 On px_tick with x == 799, y shall increment; at y == 524 it shall wrap to 0.
REQ-022 x and y are registered and shall stay stable for exactly CLK_DIV clocks per pixel.
REQ-023 frame_tick shall equal px_tick AND x == 799 AND y == 524, asserting once per 420000 pixel periods.
REQ-024 video_on shall be combinational: x < 640 AND y < 480.
REQ-025 Internal hs_raw shall be 0 when x is in [656, 752), otherwise 1.
REQ-026 Internal vs_raw shall be 0 when y is in [490, 492), otherwise 1.
REQ-027 On px_tick, hsync and vsync shall load hs_raw and vs_raw.
REQ-028 On px_tick, RGB shall load FG_COLOR if video_on AND px_data, otherwise 12'h000.
REQ-029 Registered sync/RGB outputs shall therefore lag x/y by exactly one pixel period.
REQ-030 The registered lag shall absorb the encoder's one-clk registered latency, since px_data is sampled on the last clock of the period.
REQ-031 RGB shall be 0 for every pixel outside the active area, regardless of px_data.
REQ-032 Between px_tick pulses, all registered outputs shall hold their values.
REQ-033 Sync boundary positions shall derive from the parameters: x sync = [H_ACT+H_FP, H_ACT+H_FP+H_SYNC); y likewise.
REQ-034 All arithmetic shall be unsigned, 11-bit.

Reset
REQ-035 While rst = 0: div_cnt=0, x=0, y=0, hsync=1, vsync=1, RGB=0; hence px_tick=0 and frame_tick=0.
REQ-036 Reset is asynchronous and takes effect mid-line or mid-frame with no partial-pixel completion.
REQ-037 After rst rises, the first px_tick shall occur on the CLK_DIV-th rising clk edge.
REQ-038 The first x increment (0 -> 1) shall occur on that same px_tick.

Verification
REQ-039 Pixel counting: CLK_DIV=4, rst released, px_data=1 -> px_tick every 4 clks; x=0..799 then 0; y increments at x 799 -> 0.
REQ-040 Horizontal sync: on line y=10 -> hsync goes 0 on the px_tick where x=656, returns to 1 on the px_tick where x=752; low for 96 pixels.
REQ-041 Vertical sync: full frame -> vsync low for exactly 1600 pixel periods (lines 490-491); frame_tick pulses once per 1680000 clks, on the px_tick where x=799, y=524.
REQ-042 Blanking: px_data tied 1 -> RGB=FFF only for samples taken with x<640 and y<480; RGB=000 on samples at x=640 and at y=480.
REQ-043 Pixel latency: px_data=1 only when x==100, y==50 -> RGB=FFF for exactly one pixel period, starting the px_tick after x=100 is presented.
REQ-044 Mid-frame reset: rst=0 at x=300, y=200 -> all outputs return to their reset values immediately; after release, counting restarts at x=0, y=0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, x/y scan counters, and registered
// sync/RGB outputs that lag x/y by one pixel to match the encoder's latency.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACT    = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACT    = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic [11:0] FG_COLOR = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        px_data,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        px_tick,
    output logic        frame_tick,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam logic [3:0]  DIV_LAST  = 4'(CLK_DIV - 1);
    localparam logic [10:0] H_ACT_W   = 11'(H_ACT);
    localparam logic [10:0] V_ACT_W   = 11'(V_ACT);
    localparam logic [10:0] H_SYNC_LO = 11'(H_ACT + H_FP);
    localparam logic [10:0] H_SYNC_HI = 11'(H_ACT + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_LO = 11'(V_ACT + V_FP);
    localparam logic [10:0] V_SYNC_HI = 11'(V_ACT + V_FP + V_SYNC);
    localparam logic [10:0] H_LAST    = 11'(H_ACT + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_LAST    = 11'(V_ACT + V_FP + V_SYNC + V_BP - 1);

    logic [3:0]  div_cnt_q, div_cnt_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hs_raw;
    logic        vs_raw;
    logic        x_last;
    logic        y_last;

    always_comb begin
        px_tick    = (div_cnt_q == DIV_LAST);
        x_last     = (x_q == H_LAST);
        y_last     = (y_q == V_LAST);
        frame_tick = px_tick && x_last && y_last;
        video_on   = (x_q < H_ACT_W) && (y_q < V_ACT_W);
        hs_raw     = !((x_q >= H_SYNC_LO) && (x_q < H_SYNC_HI));
        vs_raw     = !((y_q >= V_SYNC_LO) && (y_q < V_SYNC_HI));
    end

    always_comb begin
        div_cnt_d = px_tick ? '0 : div_cnt_q + 4'd1;
        x_d       = x_q;
        y_d       = y_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        rgb_d     = rgb_q;
        if (px_tick) begin
            x_d   = x_last ? '0 : x_q + 11'd1;
            if (x_last) begin
                y_d = y_last ? '0 : y_q + 11'd1;
            end
            // px_data is sampled here, on the last clock of the pixel, so the
            // registered colour lines up with the sync outputs one pixel later.
            hs_d  = hs_raw;
            vs_d  = vs_raw;
            rgb_d = (video_on && px_data) ? FG_COLOR : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            rgb_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            rgb_q     <= rgb_d;
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign hsync = hs_q;
    assign vsync = vs_q;
    assign vga_r = rgb_q[11:8];
    assign vga_g = rgb_q[7:4];
    assign vga_b = rgb_q[3:0];

endmodule
